// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// A full adder is built from two half_addr cells plus an OR gate, and a
// single carry flip-flop carries between bit positions. A start/done
// handshake lets the controlling FSM launch an operation and collect the
// result, which is held on sum/cout/ovf until the next completion.
//
// Optional build macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b (operand B inverted, carry-in forced to 1).

// Half-adder cell used twice per bit position.
module half_addr (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             s1, c1, s_bit, c2, c_bit;
  logic [WIDTH-1:0] r_next;

  // Operand B and initial carry as seen by the datapath: subtraction is
  // a + ~b + 1, so it only changes what gets loaded at start.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  half_addr u_ha0 (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .sum_o   (s1),
    .carry_o (c1)
  );

  half_addr u_ha1 (
    .a_i     (s1),
    .b_i     (carry_q),
    .sum_o   (s_bit),
    .carry_o (c2)
  );

  assign c_bit  = c1 | c2;
  // New sum bit enters at the MSB so that after WIDTH shifts the LSB
  // computed first has arrived at bit 0.
  assign r_next = {s_bit, r_sh_q[WIDTH-1:1]};

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          r_sh_d  = '0;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d  = r_next;
        carry_d = c_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q here is the carry into the MSB position.
          sum_d   = r_next;
          cout_d  = c_bit;
          ovf_d   = carry_q ^ c_bit;
          cnt_d   = cnt_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, shift registers and result registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
